ddr_init_loader: RTL and testbench
==================================

DDR_INIT_LOADER -- requirements
Module: ddr_init_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W 256: DDR beat width in bits.
- WORD_W 32: table word width in bits; DATA_W SHALL be an integer multiple of WORD_W.
- NUM_WORDS 28: table length in words, 1..1024.
- ADDR_W 25: DDR word-address width.
- BASE_ADDR 0: DDR address of the first beat.
- VERIFY 0: 1 enables per-beat readback compare.
- Derived: WPB = DATA_W/WORD_W; NUM_BEATS = ceil(NUM_WORDS/WPB).
REQ-002 Ports (name, direction, width, meaning), one per line:
- avalon_clk in 1: the single clock; all logic on its rising edge.
- avalon_reset in 1: asynchronous, active-high reset.
- cal_ok in 1: DDR calibration success level.
- start in 1: single-cycle load request.
- tbl_addr out 10: table word address.
- tbl_data in WORD_W: table word, valid 1 cycle after tbl_addr.
- wr_rq out 1: write request.
- rd_rq out 1: read request.
- wr_adr out ADDR_W: write beat address.
- rd_adr out ADDR_W: read beat address.
- wr_data out DATA_W: write beat.
- byte_enable out DATA_W/8: write byte enables.
- action_done in 1: write-complete pulse.
- rd_valid in 1: read data valid.
- rd_data in DATA_W: read beat.
- busy out 1: load in progress.
- done out 1: load complete, level.
- error out 1: at least one verify mismatch.
- err_count out 16: mismatching beats, saturating.

Function
REQ-003 FSM states: IDLE, FETCH, WRITE, RD_REQ, RD_WAIT, DONE.
REQ-004 IDLE/DONE -> FETCH when start=1 and cal_ok=1 in the same cycle. On that transition: done, error and err_count clear; the beat index clears to 0.
REQ-005 start is ignored when cal_ok=0, and ignored in every state other than IDLE and DONE.
REQ-006 FETCH, beat b: the block drives tbl_addr = b*WPB+k for k = 0..n-1, one word per cycle.
- n = WPB for every beat except the last.
- For the last beat, n = NUM_WORDS - b*WPB.
REQ-007 The word returned for index k SHALL be placed in beat bits [k*WORD_W +: WORD_W]; unfilled words are zero.
REQ-008 FETCH lasts exactly n+1 cycles, then the FSM goes to WRITE.
REQ-009 byte_enable is all ones for full beats. For the last partial beat, only the low n*WORD_W/8 bits are set (default parameters: 32'h0000FFFF).
REQ-010 WRITE: wr_rq=1 with wr_adr = BASE_ADDR+b. wr_adr, wr_data and byte_enable SHALL stay stable until action_done=1 is sampled.
REQ-011 wr_rq SHALL deassert in the cycle after action_done is sampled.
REQ-012 After a write completes: if VERIFY=1, go to RD_REQ; otherwise go to the next-beat decision.
REQ-013 RD_REQ: rd_rq=1 with rd_adr = wr_adr for one cycle, then go to RD_WAIT.
REQ-014 RD_WAIT: when rd_valid=1, compare rd_data with the held beat over the enabled bytes only. On mismatch, err_count += 1 (saturating at 16'hFFFF) and error=1.
REQ-015 Next-beat decision: if b = NUM_BEATS-1, go to DONE; otherwise b += 1 and go to FETCH.
REQ-016 action_done outside WRITE and rd_valid outside RD_WAIT SHALL be ignored.
REQ-017 busy=1 in FETCH, WRITE, RD_REQ and RD_WAIT; done=1 only in DONE. done holds until the next accepted start.
REQ-018 Address arithmetic is modulo 2^ADDR_W; BASE_ADDR+b wraps without a flag.
REQ-019 A cal_ok fall while busy does not abort the load.

Reset
REQ-020 avalon_reset=1 forces IDLE immediately, including mid-operation. The held beat clears to 0.
REQ-021 Reset values: wr_rq, rd_rq, busy, done and error = 0; tbl_addr, wr_adr, rd_adr, wr_data and err_count = 0; byte_enable = all ones.

Verification
REQ-022 Defaults, start with cal_ok=1, action_done 3 cycles after each wr_rq -> 4 writes:
- addresses 0..3 with byte_enable 32'hFFFFFFFF ×3, then 32'h0000FFFF;
- beat 0 bits [31:0] = table word 0; done=1; err_count=0.
REQ-023 start with cal_ok=0 -> busy stays 0, tbl_addr does not change, no wr_rq.
REQ-024 VERIFY=1, memory model corrupts beat 2 -> error=1, err_count=1, done=1, 4 reads issued.
REQ-025 avalon_reset during the WRITE of beat 1 -> wr_rq=0 the same cycle; a later start writes from address BASE_ADDR.
REQ-026 NUM_WORDS=8, BASE_ADDR=2^25-1 -> one beat written to 25'h1FFFFFF. A second start while done=1 re-runs the load and done returns to 0 during it.

Source files
------------

// File: rtl/ddr_init_loader_if.sv
// Bus bundle between the init loader and its table ROM / DDR controller.
// The loader is the master: it drives table addresses and DDR requests,
// and receives table words, write completions and read data.
interface ddr_init_loader_if #(
    parameter int DATA_W = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 25
);
    logic [9:0]          tbl_addr;
    logic [WORD_W-1:0]   tbl_data;
    logic                wr_rq;
    logic                rd_rq;
    logic [ADDR_W-1:0]   wr_adr;
    logic [ADDR_W-1:0]   rd_adr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] byte_enable;
    logic                action_done;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;

    modport master (
        output tbl_addr, wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable,
        input  tbl_data, action_done, rd_valid, rd_data
    );

    modport slave (
        input  tbl_addr, wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable,
        output tbl_data, action_done, rd_valid, rd_data
    );
endinterface

// File: rtl/ddr_init_loader.sv
// DDR init loader: after calibration, copies a word table into DDR one
// beat at a time (WPB words packed per beat), optionally reading each
// beat back and counting mismatching beats over the enabled bytes.
module ddr_init_loader #(
    parameter int DATA_W    = 256,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 28,
    parameter int ADDR_W    = 25,
    parameter int BASE_ADDR = 0,
    parameter int VERIFY    = 0
) (
    input  logic        avalon_clk,
    input  logic        avalon_reset,
    input  logic        cal_ok,
    input  logic        start,
    ddr_init_loader_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] err_count
);
    localparam int WPB        = DATA_W / WORD_W;
    localparam int NUM_BEATS  = (NUM_WORDS + WPB - 1) / WPB;
    localparam int LAST_N     = NUM_WORDS - (NUM_BEATS - 1) * WPB;
    localparam int BE_W       = DATA_W / 8;
    localparam int LAST_BYTES = LAST_N * WORD_W / 8;
    localparam int KW         = $clog2(WPB + 1);
    localparam int BW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [KW-1:0]   FULL_N    = KW'(WPB);
    localparam logic [KW-1:0]   LAST_NK   = KW'(LAST_N);
    localparam logic [BW-1:0]   LAST_B    = BW'(NUM_BEATS - 1);
    localparam logic [BE_W:0]   LAST_BE_X = ({{BE_W{1'b0}}, 1'b1} << LAST_BYTES) - 1'b1;
    localparam logic [BE_W-1:0] LAST_BE   = LAST_BE_X[BE_W-1:0];

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RD_REQ, RD_WAIT, DONE} state_t;

    state_t            state;
    logic [BW-1:0]     beat_idx;
    logic [KW-1:0]     fcnt;
    logic [9:0]        tbl_addr_q;
    logic [DATA_W-1:0] beat;
    logic              wr_rq_q;
    logic              rd_rq_q;
    logic [ADDR_W-1:0] wr_adr_q;
    logic [ADDR_W-1:0] rd_adr_q;
    logic [BE_W-1:0]   be_q;
    logic [KW-1:0]     n_cur;
    logic [DATA_W-1:0] bit_mask;
    logic              mismatch;

    assign bus.tbl_addr    = tbl_addr_q;
    assign bus.wr_rq       = wr_rq_q;
    assign bus.rd_rq       = rd_rq_q;
    assign bus.wr_adr      = wr_adr_q;
    assign bus.rd_adr      = rd_adr_q;
    assign bus.wr_data     = beat;
    assign bus.byte_enable = be_q;

    assign n_cur    = (beat_idx == LAST_B) ? LAST_NK : FULL_N;
    assign mismatch = |((bus.rd_data ^ beat) & bit_mask);

    // Expand the byte enables of the held beat into a per-bit compare mask.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            bit_mask[i*8 +: 8] = {8{be_q[i]}};
        end
    end

    // Load sequencer: fetch words, write the beat, optionally read it back.
    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            state      <= IDLE;
            beat_idx   <= '0;
            fcnt       <= '0;
            tbl_addr_q <= '0;
            beat       <= '0;
            wr_rq_q    <= 1'b0;
            rd_rq_q    <= 1'b0;
            wr_adr_q   <= '0;
            rd_adr_q   <= '0;
            be_q       <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && cal_ok) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_count  <= '0;
                        beat_idx   <= '0;
                        fcnt       <= '0;
                        tbl_addr_q <= '0;
                        beat       <= '0;
                    end
                end
                FETCH: begin
                    for (int i = 0; i < WPB; i++) begin
                        if (fcnt == KW'(i + 1)) begin
                            beat[i*WORD_W +: WORD_W] <= bus.tbl_data;
                        end
                    end
                    if (fcnt == n_cur) begin
                        state    <= WRITE;
                        wr_rq_q  <= 1'b1;
                        wr_adr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(beat_idx);
                        be_q     <= (beat_idx == LAST_B) ? LAST_BE : '1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                        if (fcnt < n_cur - 1'b1) begin
                            tbl_addr_q <= tbl_addr_q + 10'd1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.action_done) begin
                        wr_rq_q <= 1'b0;
                        if (VERIFY != 0) begin
                            state    <= RD_REQ;
                            rd_rq_q  <= 1'b1;
                            rd_adr_q <= wr_adr_q;
                        end else if (beat_idx == LAST_B) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            beat_idx   <= beat_idx + 1'b1;
                            fcnt       <= '0;
                            tbl_addr_q <= tbl_addr_q + 10'd1;
                            beat       <= '0;
                        end
                    end
                end
                RD_REQ: begin
                    rd_rq_q <= 1'b0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.rd_valid) begin
                        if (mismatch) begin
                            error <= 1'b1;
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                        end
                        if (beat_idx == LAST_B) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            beat_idx   <= beat_idx + 1'b1;
                            fcnt       <= '0;
                            tbl_addr_q <= tbl_addr_q + 10'd1;
                            beat       <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_init_loader.sv
// Directed bench for ddr_init_loader: three instances (defaults, readback
// verify with a corrupting memory, single beat at the top of the address space).
module tb_ddr_init_loader;
    logic avalon_clk = 1'b0;
    logic avalon_reset;
    logic cal_ok;
    logic start_d, start_v, start_s;
    logic busy_d, done_d, error_d;
    logic busy_v, done_v, error_v;
    logic busy_s, done_s, error_s;
    logic [15:0] errc_d, errc_v, errc_s;
    int n_cmp = 0;
    int n_bad = 0;

    ddr_init_loader_if #(.DATA_W(256), .WORD_W(32), .ADDR_W(25)) bus_d ();
    ddr_init_loader_if #(.DATA_W(256), .WORD_W(32), .ADDR_W(25)) bus_v ();
    ddr_init_loader_if #(.DATA_W(256), .WORD_W(32), .ADDR_W(25)) bus_s ();

    ddr_init_loader u_d (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset), .cal_ok(cal_ok), .start(start_d),
        .bus(bus_d), .busy(busy_d), .done(done_d), .error(error_d), .err_count(errc_d)
    );

    ddr_init_loader #(.VERIFY(1)) u_v (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset), .cal_ok(cal_ok), .start(start_v),
        .bus(bus_v), .busy(busy_v), .done(done_v), .error(error_v), .err_count(errc_v)
    );

    ddr_init_loader #(.NUM_WORDS(8), .BASE_ADDR(33554431)) u_s (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset), .cal_ok(cal_ok), .start(start_s),
        .bus(bus_s), .busy(busy_s), .done(done_s), .error(error_s), .err_count(errc_s)
    );

    always #5 avalon_clk = ~avalon_clk;

    function automatic logic [31:0] tbl_word(input logic [9:0] a);
        return 32'hA5A5_0000 + 32'(a);
    endfunction

    function automatic logic [255:0] exp_beat(input int b, input int nw);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (b * 8 + k < nw) r[k*32 +: 32] = tbl_word(10'(b * 8 + k));
        end
        return r;
    endfunction

    // Table ROMs with one cycle of read latency.
    always @(posedge avalon_clk) begin
        bus_d.tbl_data <= tbl_word(bus_d.tbl_addr);
        bus_v.tbl_data <= tbl_word(bus_v.tbl_addr);
        bus_s.tbl_data <= tbl_word(bus_s.tbl_addr);
    end

    assign bus_d.rd_valid = 1'b0;
    assign bus_d.rd_data  = '0;
    assign bus_s.rd_valid = 1'b0;
    assign bus_s.rd_data  = '0;

    int nw_d, nw_v, nw_s, cnt_d, cnt_v, cnt_s, nr_v;
    logic [24:0]  adr_d[8], adr_v[8], adr_s[8];
    logic [31:0]  be_d[8], be_v[8], be_s[8];
    logic [255:0] dat_d[8], dat_v[8], dat_s[8];

    // Write responder for the default instance: completes each write 3 cycles in.
    always @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            bus_d.action_done <= 1'b0; cnt_d <= 0; nw_d <= 0;
        end else if (bus_d.action_done) begin
            bus_d.action_done <= 1'b0; cnt_d <= 0;
        end else if (bus_d.wr_rq) begin
            if (cnt_d == 2) begin
                bus_d.action_done <= 1'b1;
                if (nw_d < 8) begin
                    adr_d[nw_d[2:0]] <= bus_d.wr_adr;
                    be_d[nw_d[2:0]]  <= bus_d.byte_enable;
                    dat_d[nw_d[2:0]] <= bus_d.wr_data;
                end
                nw_d <= nw_d + 1;
            end else cnt_d <= cnt_d + 1;
        end
    end

    // Write responder for the verify instance.
    always @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            bus_v.action_done <= 1'b0; cnt_v <= 0; nw_v <= 0;
        end else if (bus_v.action_done) begin
            bus_v.action_done <= 1'b0; cnt_v <= 0;
        end else if (bus_v.wr_rq) begin
            if (cnt_v == 2) begin
                bus_v.action_done <= 1'b1;
                if (nw_v < 8) begin
                    adr_v[nw_v[2:0]] <= bus_v.wr_adr;
                    be_v[nw_v[2:0]]  <= bus_v.byte_enable;
                    dat_v[nw_v[2:0]] <= bus_v.wr_data;
                end
                nw_v <= nw_v + 1;
            end else cnt_v <= cnt_v + 1;
        end
    end

    // Write responder for the single-beat instance.
    always @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            bus_s.action_done <= 1'b0; cnt_s <= 0; nw_s <= 0;
        end else if (bus_s.action_done) begin
            bus_s.action_done <= 1'b0; cnt_s <= 0;
        end else if (bus_s.wr_rq) begin
            if (cnt_s == 2) begin
                bus_s.action_done <= 1'b1;
                if (nw_s < 8) begin
                    adr_s[nw_s[2:0]] <= bus_s.wr_adr;
                    be_s[nw_s[2:0]]  <= bus_s.byte_enable;
                    dat_s[nw_s[2:0]] <= bus_s.wr_data;
                end
                nw_s <= nw_s + 1;
            end else cnt_s <= cnt_s + 1;
        end
    end

    logic       rpend;
    logic [1:0] radr;

    // Read responder: beat 2 comes back with bit 0 flipped, beat 3 with junk in disabled bytes.
    always @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            bus_v.rd_valid <= 1'b0; bus_v.rd_data <= '0; rpend <= 1'b0; radr <= '0; nr_v <= 0;
        end else begin
            bus_v.rd_valid <= 1'b0;
            if (bus_v.rd_rq) begin
                rpend <= 1'b1; radr <= bus_v.rd_adr[1:0]; nr_v <= nr_v + 1;
            end else if (rpend) begin
                rpend <= 1'b0;
                bus_v.rd_valid <= 1'b1;
                case (radr)
                    2'd2:    bus_v.rd_data <= dat_v[3'd2] ^ 256'h1;
                    2'd3:    bus_v.rd_data <= dat_v[3'd3] | {128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 128'h0};
                    default: bus_v.rd_data <= dat_v[{1'b0, radr}];
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int which);
        @(negedge avalon_clk);
        case (which)
            0:       start_d = 1'b1;
            1:       start_v = 1'b1;
            default: start_s = 1'b1;
        endcase
        @(negedge avalon_clk);
        start_d = 1'b0; start_v = 1'b0; start_s = 1'b0;
    endtask

    function automatic logic doneOf(input int which);
        case (which)
            0:       return done_d;
            1:       return done_v;
            default: return done_s;
        endcase
    endfunction

    task automatic waitDone(input int which, input string tag);
        int c;
        c = 0;
        while (!doneOf(which) && c < 1000) begin
            @(negedge avalon_clk);
            c++;
        end
        checkOutput(tag, 256'(doneOf(which)), 256'(1));
    endtask

    initial begin
        int c;
        avalon_reset = 1'b1; cal_ok = 1'b0;
        start_d = 1'b0; start_v = 1'b0; start_s = 1'b0;
        repeat (3) @(negedge avalon_clk);
        avalon_reset = 1'b0;
        @(negedge avalon_clk);

        checkOutput("rst_flags", 256'({busy_d, done_d, error_d, bus_d.wr_rq, bus_d.rd_rq}), 256'(0));
        checkOutput("rst_addrs", 256'({bus_d.tbl_addr, bus_d.wr_adr, bus_d.rd_adr, errc_d}), 256'(0));
        checkOutput("rst_wr_data", bus_d.wr_data, 256'(0));
        checkOutput("rst_byte_enable", 256'(bus_d.byte_enable), 256'(32'hFFFF_FFFF));

        // Start without calibration is ignored.
        applyStimulus(0);
        repeat (4) @(negedge avalon_clk);
        checkOutput("nocal_busy", 256'(busy_d), 256'(0));
        checkOutput("nocal_tbl_addr", 256'(bus_d.tbl_addr), 256'(0));
        checkOutput("nocal_writes", 256'(nw_d), 256'(0));

        // Full default load.
        cal_ok = 1'b1;
        applyStimulus(0);
        checkOutput("run_busy", 256'({busy_d, done_d}), 256'(2'b10));
        checkOutput("fetch_addr0", 256'(bus_d.tbl_addr), 256'(0));
        @(negedge avalon_clk);
        checkOutput("fetch_addr1", 256'(bus_d.tbl_addr), 256'(1));
        waitDone(0, "def_done");
        checkOutput("def_writes", 256'(nw_d), 256'(4));
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("def_adr%0d", b), 256'(adr_d[b]), 256'(b));
            checkOutput($sformatf("def_be%0d", b), 256'(be_d[b]),
                        256'((b < 3) ? 32'hFFFF_FFFF : 32'h0000_FFFF));
            checkOutput($sformatf("def_data%0d", b), dat_d[b], exp_beat(b, 28));
        end
        checkOutput("def_word0", 256'(dat_d[0][31:0]), 256'(32'hA5A5_0000));
        checkOutput("def_beat3_hi", 256'(dat_d[3][255:128]), 256'(0));
        checkOutput("def_status", 256'({busy_d, error_d, errc_d}), 256'(0));

        // Reset in the middle of the beat 1 write, then reload from the base.
        applyStimulus(0);
        c = 0;
        while (!(bus_d.wr_rq && bus_d.wr_adr == 25'd1) && c < 500) begin
            @(negedge avalon_clk);
            c++;
        end
        checkOutput("midwrite_reached", 256'(bus_d.wr_rq && bus_d.wr_adr == 25'd1), 256'(1));
        avalon_reset = 1'b1;
        #1;
        checkOutput("midrst_wr_rq", 256'(bus_d.wr_rq), 256'(0));
        checkOutput("midrst_state", 256'({busy_d, done_d}), 256'(0));
        checkOutput("midrst_beat", bus_d.wr_data, 256'(0));
        @(negedge avalon_clk);
        avalon_reset = 1'b0;
        applyStimulus(0);
        waitDone(0, "reload_done");
        checkOutput("reload_writes", 256'(nw_d), 256'(4));
        checkOutput("reload_adr0", 256'(adr_d[0]), 256'(0));

        // Readback verify with one corrupted beat.
        applyStimulus(1);
        waitDone(1, "ver_done");
        checkOutput("ver_error", 256'(error_v), 256'(1));
        checkOutput("ver_err_count", 256'(errc_v), 256'(1));
        checkOutput("ver_reads", 256'(nr_v), 256'(4));
        checkOutput("ver_writes", 256'(nw_v), 256'(4));

        // Single full beat at the last DDR address, then a restart from DONE.
        applyStimulus(2);
        waitDone(2, "small_done");
        checkOutput("small_writes", 256'(nw_s), 256'(1));
        checkOutput("small_adr", 256'(adr_s[0]), 256'(25'h1FF_FFFF));
        checkOutput("small_be", 256'(be_s[0]), 256'(32'hFFFF_FFFF));
        checkOutput("small_data", dat_s[0], exp_beat(0, 8));
        applyStimulus(2);
        checkOutput("rerun_state", 256'({busy_s, done_s}), 256'(2'b10));
        waitDone(2, "rerun_done");
        checkOutput("rerun_writes", 256'(nw_s), 256'(2));
        checkOutput("rerun_adr", 256'(adr_s[1]), 256'(25'h1FF_FFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
